fetch_ctrl: RTL and testbench

Fetch sequencer that drives the program-counter register through its next_pc/pc_sel/halt controls. It issues instruction-memory requests at the current PC using a req/gnt then rvalid handshake. Fetched instructions go to decode over a valid/ready interface. It also applies branch/jump redirects from execute and a halt request.

---
 rtl/fetch_ctrl_if.sv | 46 ++++
 rtl/fetch_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
// Bundles the two handshake buses of the fetch sequencer:
//   - instruction-memory request/response (req/gnt, then rvalid/rdata)
//   - fetched-instruction channel to decode (valid/ready)
// Modports:
//   master : the fetch sequencer side (drives req/addr and instr_*)
//   slave  : the memory + decode side (drives gnt/rvalid/rdata and ready)
// -----------------------------------------------------------------------------
interface fetch_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_gnt;
    logic             imem_rvalid;
    logic [WIDTH-1:0] imem_rdata;
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] instr_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Fetch sequencer. Steers an external PC register (next_pc / pc_sel / halt),
// fetches one instruction at a time from instruction memory at the current
// PC and hands it to decode. Redirects from execute reload the PC; fetches
// that were in flight when a redirect arrived are discarded.
//
// Ports:
//   clk, rst_i          clock, asynchronous active-low reset
//   pc                  current PC register value
//   next_pc, pc_sel     PC load value / select (1 = load next_pc, 0 = +4)
//   halt                1 = PC register holds its value this cycle
//   bus (master)        imem req/gnt/rvalid bus and decode valid/ready bus
//   redirect_valid      one-cycle redirect pulse from execute
//   redirect_target     redirect address (low two bits ignored)
//   halt_req            level request to stop fetching
//   halted              1 while the sequencer sits in HALT
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] next_pc,
    output logic             pc_sel,
    output logic             halt,
    fetch_ctrl_if.master     bus,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             halt_req,
    output logic             halted
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_OUT  = 3'd3,
        ST_HALT = 3'd4
    } state_e;

    // Instructions are word aligned: redirect targets lose their low two bits.
    localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic             instr_valid_q, instr_valid_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic [WIDTH-1:0] redir_aligned_s;

    assign redir_aligned_s = redirect_target & ALIGN_MASK;

    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= ST_IDLE;
            instr_q       <= {WIDTH{1'b0}};
            instr_pc_q    <= {WIDTH{1'b0}};
            instr_valid_q <= 1'b0;
            pend_q        <= 1'b0;
            pend_tgt_q    <= {WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            pend_q        <= pend_d;
            pend_tgt_q    <= pend_tgt_d;
        end
    end

    // Next-state and PC/memory control decode.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        pend_d        = pend_q;
        pend_tgt_d    = pend_tgt_q;
        halt          = 1'b1;
        pc_sel        = 1'b0;
        next_pc       = redir_aligned_s;
        bus.imem_req  = 1'b0;
        bus.imem_addr = pc;
        halted        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // rst_i gate keeps pc_sel low while reset is asserted.
                if (redirect_valid && rst_i) begin
                    pc_sel = 1'b1;
                    halt   = 1'b0;
                end else begin
                    pc_sel = 1'b0;
                end
                if (halt_req) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                // PC is frozen here, so imem_addr stays stable until gnt.
                bus.imem_req = 1'b1;
                if (redirect_valid) begin
                    pend_d     = 1'b1;
                    pend_tgt_d = redir_aligned_s;
                end else begin
                    pend_d = pend_q;
                end
                if (bus.imem_gnt) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end

            ST_WAIT: begin
                if (bus.imem_rvalid) begin
                    if (redirect_valid || pend_q) begin
                        // Response belongs to the abandoned path: drop it and
                        // load the newest redirect target instead.
                        pc_sel  = 1'b1;
                        halt    = 1'b0;
                        next_pc = redirect_valid ? redir_aligned_s : pend_tgt_q;
                        pend_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        instr_d       = bus.imem_rdata;
                        instr_pc_d    = pc;
                        instr_valid_d = 1'b1;
                        halt          = 1'b0;
                        state_d       = ST_OUT;
                    end
                end else if (redirect_valid) begin
                    pend_d     = 1'b1;
                    pend_tgt_d = redir_aligned_s;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_OUT: begin
                // A redirect retires the held instruction even without ready.
                if (redirect_valid) begin
                    instr_valid_d = 1'b0;
                    pc_sel        = 1'b1;
                    halt          = 1'b0;
                    state_d       = halt_req ? ST_HALT : ST_REQ;
                end else if (bus.instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = halt_req ? ST_HALT : ST_REQ;
                end else begin
                    state_d = ST_OUT;
                end
            end

            ST_HALT: begin
                halted = 1'b1;
                if (redirect_valid) begin
                    pc_sel = 1'b1;
                    halt   = 1'b0;
                end else begin
                    pc_sel = 1'b0;
                end
                if (halt_req) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d       = ST_IDLE;
                instr_valid_d = 1'b0;
                pend_d        = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed walk through the fetch sequencer's main scenarios followed by a
// randomized run against a small memory responder and an instruction-stream
// reference model (expected PC advances by 4 per delivered instruction and
// jumps to the aligned target on every redirect).
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_i;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] next_pc;
    logic             pc_sel;
    logic             halt;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             halt_req;
    logic             halted;

    int n_vec;
    int n_err;

    fetch_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

    fetch_ctrl #(.WIDTH(WIDTH)) dut (
        .clk             (clk),
        .rst_i           (rst_i),
        .pc              (pc),
        .next_pc         (next_pc),
        .pc_sel          (pc_sel),
        .halt            (halt),
        .bus             (bus_if),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .halted          (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program-counter register steered by the DUT.
    always @(posedge clk or negedge rst_i) begin
        if (!rst_i)
            pc <= 32'd0;
        else if (!halt)
            pc <= pc_sel ? next_pc : pc + 32'd4;
    end

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC3A5_0F1E;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_if.imem_gnt    = 1'b0;
        bus_if.imem_rvalid = 1'b0;
        bus_if.imem_rdata  = 32'd0;
        bus_if.instr_ready = 1'b0;
        redirect_valid     = 1'b0;
        redirect_target    = 32'd0;
    endtask

    // Randomized-phase state
    logic [31:0] exp_pc;
    logic [31:0] maddr;
    logic [31:0] prev_instr, prev_ipc;
    logic        outst, outst0, prev_valid, prev_consumed;
    int          lat, idle_cnt, delivered;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_i = 1'b0;
        halt_req = 1'b0;
        idle_inputs();

        // ---------------- reset state ----------------
        #3;
        chk("rst_halt",   32'(halt), 32'd1);
        chk("rst_pc_sel", 32'(pc_sel), 32'd0);
        chk("rst_req",    32'(bus_if.imem_req), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_valid",  32'(bus_if.instr_valid), 32'd0);
        chk("rst_instr",  bus_if.instr, 32'd0);
        chk("rst_ipc",    bus_if.instr_pc, 32'd0);

        // ---------------- first fetch at 0x0 ----------------
        @(negedge clk); rst_i = 1'b1; #1;
        chk("idle_pc_sel", 32'(pc_sel), 32'd0);
        chk("idle_halt",   32'(halt), 32'd1);
        @(negedge clk); bus_if.imem_gnt = 1'b1; #1;
        chk("req0_req",  32'(bus_if.imem_req), 32'd1);
        chk("req0_addr", bus_if.imem_addr, 32'h0);
        @(negedge clk); bus_if.imem_gnt = 1'b0;
        bus_if.imem_rvalid = 1'b1; bus_if.imem_rdata = 32'h0000_0013; #1;
        chk("wait0_halt",   32'(halt), 32'd0);
        chk("wait0_pc_sel", 32'(pc_sel), 32'd0);
        chk("wait0_req",    32'(bus_if.imem_req), 32'd0);

        // ---------------- decode back-pressure for 5 cycles ----------------
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); bus_if.imem_rvalid = 1'b0; #1;
            chk("out0_valid", 32'(bus_if.instr_valid), 32'd1);
            chk("out0_instr", bus_if.instr, 32'h13);
            chk("out0_ipc",   bus_if.instr_pc, 32'h0);
            chk("out0_noreq", 32'(bus_if.imem_req), 32'd0);
            chk("out0_pc",    pc, 32'h4);
        end
        @(negedge clk); bus_if.instr_ready = 1'b1; #1;
        chk("out0_hs_halt", 32'(halt), 32'd1);
        @(negedge clk); bus_if.instr_ready = 1'b0; bus_if.imem_gnt = 1'b1; #1;
        chk("req1_addr",  bus_if.imem_addr, 32'h4);
        chk("req1_req",   32'(bus_if.imem_req), 32'd1);
        chk("req1_valid", 32'(bus_if.instr_valid), 32'd0);

        // ---------------- redirect during WAIT drops the response ----------------
        @(negedge clk); bus_if.imem_gnt = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h103; #1;
        chk("wredir_pc_sel", 32'(pc_sel), 32'd0);
        chk("wredir_halt",   32'(halt), 32'd1);
        @(negedge clk); redirect_valid = 1'b0;
        bus_if.imem_rvalid = 1'b1; bus_if.imem_rdata = 32'hDEAD_BEEF; #1;
        chk("drop_pc_sel",  32'(pc_sel), 32'd1);
        chk("drop_next_pc", next_pc, 32'h100);
        chk("drop_halt",    32'(halt), 32'd0);
        @(negedge clk); bus_if.imem_rvalid = 1'b0; bus_if.imem_gnt = 1'b1; #1;
        chk("drop_valid", 32'(bus_if.instr_valid), 32'd0);
        chk("req2_addr",  bus_if.imem_addr, 32'h100);

        // ---------------- halt_req during WAIT ----------------
        @(negedge clk); bus_if.imem_gnt = 1'b0; halt_req = 1'b1;
        bus_if.imem_rvalid = 1'b1; bus_if.imem_rdata = 32'h1111_1111; #1;
        chk("hwait_halt", 32'(halt), 32'd0);
        @(negedge clk); bus_if.imem_rvalid = 1'b0; bus_if.instr_ready = 1'b1; #1;
        chk("hout_instr", bus_if.instr, 32'h1111_1111);
        chk("hout_ipc",   bus_if.instr_pc, 32'h100);
        chk("hout_valid", 32'(bus_if.instr_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); bus_if.instr_ready = 1'b0; #1;
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_noreq",  32'(bus_if.imem_req), 32'd0);
            chk("halt_pc",     pc, 32'h104);
        end
        @(negedge clk); halt_req = 1'b0; #1;
        chk("unhalt_halted", 32'(halted), 32'd1);
        @(negedge clk); bus_if.imem_gnt = 1'b1; #1;
        chk("resume_req",    32'(bus_if.imem_req), 32'd1);
        chk("resume_addr",   bus_if.imem_addr, 32'h104);
        chk("resume_halted", 32'(halted), 32'd0);

        // ---------------- redirect together with ready in OUT ----------------
        @(negedge clk); bus_if.imem_gnt = 1'b0;
        bus_if.imem_rvalid = 1'b1; bus_if.imem_rdata = 32'h22; #1;
        @(negedge clk); bus_if.imem_rvalid = 1'b0; bus_if.instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'h200; #1;
        chk("oredir_pc_sel",  32'(pc_sel), 32'd1);
        chk("oredir_next_pc", next_pc, 32'h200);
        chk("oredir_halt",    32'(halt), 32'd0);

        // ---------------- gnt withheld for 4 cycles ----------------
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle_inputs(); #1;
            chk("stall_valid", 32'(bus_if.instr_valid), 32'd0);
            chk("stall_req",   32'(bus_if.imem_req), 32'd1);
            chk("stall_addr",  bus_if.imem_addr, 32'h200);
        end
        @(negedge clk); bus_if.imem_gnt = 1'b1; #1;
        chk("stall_gnt_addr", bus_if.imem_addr, 32'h200);

        // ---------------- asynchronous reset mid-WAIT ----------------
        @(negedge clk); bus_if.imem_gnt = 1'b0; halt_req = 1'b1; #1;
        chk("mid_wait_halted", 32'(halted), 32'd0);
        #2; rst_i = 1'b0; #1;
        chk("arst_halt",   32'(halt), 32'd1);
        chk("arst_pc_sel", 32'(pc_sel), 32'd0);
        chk("arst_req",    32'(bus_if.imem_req), 32'd0);
        chk("arst_valid",  32'(bus_if.instr_valid), 32'd0);
        chk("arst_halted", 32'(halted), 32'd0);
        chk("arst_instr",  bus_if.instr, 32'd0);
        halt_req = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_i = 1'b1;

        // ---------------- redirect in IDLE ----------------
        redirect_valid = 1'b1; redirect_target = 32'h37; #1;
        chk("idle_redir_pc_sel",  32'(pc_sel), 32'd1);
        chk("idle_redir_next_pc", next_pc, 32'h34);
        chk("idle_redir_halt",    32'(halt), 32'd0);

        // ---------------- randomized run ----------------
        exp_pc = 32'h34;
        outst = 1'b0; lat = 0; maddr = 32'd0;
        prev_valid = 1'b0; prev_consumed = 1'b0;
        prev_instr = 32'd0; prev_ipc = 32'd0;
        idle_cnt = 0; delivered = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            idle_cnt++;
            if (bus_if.instr_valid) begin
                if (!prev_valid || prev_consumed) begin
                    chk("rnd_ipc",   bus_if.instr_pc, exp_pc);
                    chk("rnd_instr", bus_if.instr, memf(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    delivered++;
                    idle_cnt = 0;
                end else begin
                    chk("rnd_hold_instr", bus_if.instr, prev_instr);
                    chk("rnd_hold_ipc",   bus_if.instr_pc, prev_ipc);
                end
            end
            if (halt_req)
                idle_cnt = 0;
            if (idle_cnt == 400)
                chk("rnd_watchdog", 32'(idle_cnt), 32'd0);

            // Memory responder: one response per grant after 0..3 extra cycles.
            outst0 = outst;
            bus_if.imem_rvalid = 1'b0;
            bus_if.imem_rdata  = 32'($urandom);
            if (outst) begin
                if (lat == 0) begin
                    bus_if.imem_rvalid = 1'b1;
                    bus_if.imem_rdata  = memf(maddr);
                    outst = 1'b0;
                end else begin
                    lat--;
                end
            end
            bus_if.imem_gnt = 1'b0;
            if (bus_if.imem_req) begin
                chk("rnd_single_outstanding", 32'(outst0), 32'd0);
                if ($urandom_range(0, 2) != 0) begin
                    bus_if.imem_gnt = 1'b1;
                    outst = 1'b1;
                    maddr = bus_if.imem_addr;
                    lat   = int'($urandom_range(0, 3));
                end
            end

            redirect_valid     = ($urandom_range(0, 11) == 0);
            redirect_target    = 32'($urandom);
            bus_if.instr_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0)
                halt_req = ~halt_req;
            #1;
            chk("rnd_pcsel_runs", 32'(pc_sel & halt), 32'd0);
            if (redirect_valid)
                exp_pc = redirect_target & 32'hFFFF_FFFC;
            prev_valid    = bus_if.instr_valid;
            prev_consumed = bus_if.instr_valid & (bus_if.instr_ready | redirect_valid);
            prev_instr    = bus_if.instr;
            prev_ipc      = bus_if.instr_pc;
        end
        chk("rnd_progress", 32'(delivered > 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
